// File: rtl/ex_div.sv
// Iterative 32-bit divider for the EX stage.
// Computes quotient (result_lo) and remainder (result_hi), signed or unsigned,
// with a restoring shift/subtract datapath that retires one quotient bit per
// cycle. Divide-by-zero short-circuits to zero results. The pipeline is stalled
// while a divide is pending, and a flush (annul) abandons it.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        ready,
  output logic        stallreq
);

  typedef enum logic [1:0] {
    StFree,
    StByZero,
    StOn,
    StEnd
  } state_e;

  state_e state_q, state_d;

  // Iteration counter: counts completed quotient bits while in StOn.
  logic [5:0]  cnt_q;
  // Partial remainder in [64:33], unconsumed dividend bits / growing quotient
  // in [32:0]. Bit 64 must take part in the compare: a partial remainder with
  // its top bit set, once shifted, still exceeds any 32-bit divisor.
  logic [64:0] dividend_q;
  logic [31:0] divisor_q;
  // Sign fixups captured with the operands so later operand changes are moot.
  logic        neg_quot_q;
  logic        neg_rem_q;

  // Operand conditioning.
  logic        op1_neg;
  logic        op2_neg;
  logic [31:0] op1_abs;
  logic [31:0] op2_abs;

  // One restoring step.
  logic        fits;
  logic [31:0] diff;
  logic [64:0] step;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic        last_iter;

  // Control strobes decoded from the state.
  logic        accept;
  logic        iterate;
  logic        load_div;
  logic        load_zero;
  logic        release_end;

  // Absolute values of the operands in signed mode; the most negative value
  // maps onto itself, which is exactly what the wrapping overflow case needs.
  always_comb begin
    op1_neg = signed_div & opdata1[31];
    op2_neg = signed_div & opdata2[31];
    op1_abs = op1_neg ? (~opdata1 + 32'd1) : opdata1;
    op2_abs = op2_neg ? (~opdata2 + 32'd1) : opdata2;
  end

  // Restoring division step and the sign-corrected results it would yield.
  always_comb begin
    fits     = dividend_q[64:32] >= {1'b0, divisor_q};
    // The low 32 bits of the difference are all that survive when it fits.
    diff     = dividend_q[63:32] - divisor_q;
    step     = fits ? {diff, dividend_q[31:0], 1'b1} : {dividend_q[63:0], 1'b0};
    quot_raw = step[31:0];
    rem_raw  = step[64:33];
    quot_fix = neg_quot_q ? (~quot_raw + 32'd1) : quot_raw;
    rem_fix  = neg_rem_q ? (~rem_raw + 32'd1) : rem_raw;
    last_iter = (cnt_q == 6'd31);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFree;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFree: begin
        if (start && !annul) begin
          state_d = (opdata2 == 32'd0) ? StByZero : StOn;
        end
      end
      StByZero: begin
        state_d = annul ? StFree : StEnd;
      end
      StOn: begin
        if (annul) begin
          state_d = StFree;
        end else if (last_iter) begin
          state_d = StEnd;
        end
      end
      StEnd: begin
        // annul is deliberately ignored here: the result is already committed.
        if (!start) begin
          state_d = StFree;
        end
      end
      default: state_d = StFree;
    endcase
  end

  // FSM outputs: datapath strobes and the pipeline stall request.
  always_comb begin
    accept      = 1'b0;
    iterate     = 1'b0;
    load_div    = 1'b0;
    load_zero   = 1'b0;
    release_end = 1'b0;
    unique case (state_q)
      StFree:   accept      = start & ~annul;
      StByZero: load_zero   = ~annul;
      StOn: begin
        iterate  = ~annul;
        load_div = ~annul & last_iter;
      end
      StEnd:    release_end = ~start;
      default: ;
    endcase
    // Drops in the same cycle ready rises, since ready is the registered result.
    stallreq = start & ~annul & ~ready;
  end

  // Operand capture and one shift/subtract iteration per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 6'd0;
      dividend_q <= 65'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (accept) begin
      cnt_q      <= 6'd0;
      dividend_q <= {32'd0, op1_abs, 1'b0};
      divisor_q  <= op2_abs;
      neg_quot_q <= op1_neg ^ op2_neg;
      neg_rem_q  <= op1_neg;
    end else if (iterate) begin
      cnt_q      <= cnt_q + 6'd1;
      dividend_q <= step;
    end
  end

  // Result registers: loaded on completion, cleared when the result is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_lo <= 32'd0;
      result_hi <= 32'd0;
      ready     <= 1'b0;
    end else if (load_div) begin
      result_lo <= quot_fix;
      result_hi <= rem_fix;
      ready     <= 1'b1;
    end else if (load_zero) begin
      result_lo <= 32'd0;
      result_hi <= 32'd0;
      ready     <= 1'b1;
    end else if (release_end) begin
      result_lo <= 32'd0;
      result_hi <= 32'd0;
      ready     <= 1'b0;
    end
  end

endmodule
